// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state type, default opcode width and op-index constants
// for alu_op_sequencer (optional zero flag via ALU_SEQ_ZFLAG_EN).
package alu_seq_pkg;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;
    localparam int OP_W_DEF = 12;
    localparam logic [7:0] OP_ADD    = 8'd0;
    localparam logic [7:0] OP_SUB    = 8'd1;
    localparam logic [7:0] OP_AND    = 8'd2;
    localparam logic [7:0] OP_OR     = 8'd3;
    localparam logic [7:0] OP_XOR    = 8'd4;
    localparam logic [7:0] OP_SLL    = 8'd5;
    localparam logic [7:0] OP_SRL    = 8'd6;
    localparam logic [7:0] OP_SRA    = 8'd7;
    localparam logic [7:0] OP_SLT    = 8'd8;
    localparam logic [7:0] OP_SLTU   = 8'd9;
    localparam logic [7:0] OP_COPY_A = 8'd10;
    localparam logic [7:0] OP_COPY_B = 8'd11;
endpackage

// File: rtl/op_onehot_dec.sv
// op_onehot_dec: combinational 8-bit op index to one-hot function code,
// flagging indices beyond the code width as invalid.
module op_onehot_dec
    import alu_seq_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic [7:0]      i_idx,
    output logic [OP_W-1:0] o_onehot,
    output logic            o_invalid
);
    logic w_invalid;
    assign w_invalid = 32'(i_idx) >= OP_W;
    assign o_invalid = w_invalid;
    assign o_onehot  = w_invalid ? '0 : OP_W'(1) << i_idx;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: collects op/a/b frames from a byte stream, drives an external
// ALU and holds its result until consumed. ALU_SEQ_ZFLAG_EN adds res_zero.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_f,
    input  logic [DATA_W-1:0] alu_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err
`ifdef ALU_SEQ_ZFLAG_EN
    ,
    output logic              res_zero
`endif
);
    localparam int NB = DATA_W / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_err;
    logic [OP_W-1:0]   w_onehot;
    logic              w_invalid;
    logic              w_fire;
    logic              w_last;
    logic [DATA_W-1:0] w_y;

    op_onehot_dec #(.OP_W(OP_W)) u_dec (
        .i_idx     (in_data),
        .o_onehot  (w_onehot),
        .o_invalid (w_invalid)
    );

    assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    assign res_valid = r_state == ST_HOLD;
    assign w_fire    = in_valid && in_ready;
    assign w_last    = r_cnt == CW'(NB - 1);
    // An invalid op forces a zero result regardless of what the ALU produces.
    assign w_y       = r_err ? '0 : alu_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_f    <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
            res_zero <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (w_fire) begin
                    alu_f   <= w_onehot;
                    r_err   <= w_invalid;
                    r_cnt   <= '0;
                    r_state <= ST_LOAD_A;
                end
                ST_LOAD_A: if (w_fire) begin
                    alu_a[{r_cnt, 3'b000} +: 8] <= in_data;
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                    r_state <= w_last ? ST_LOAD_B : ST_LOAD_A;
                end
                ST_LOAD_B: if (w_fire) begin
                    alu_b[{r_cnt, 3'b000} +: 8] <= in_data;
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                    r_state <= w_last ? ST_EXEC : ST_LOAD_B;
                end
                ST_EXEC: begin
                    res_data <= w_y;
                    res_err  <= r_err;
`ifdef ALU_SEQ_ZFLAG_EN
                    res_zero <= w_y == '0;
`endif
                    r_state  <= ST_HOLD;
                end
                ST_HOLD: if (res_ready) begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed frames against a small ALU model (op1 subtracts,
// everything else adds), checked with immediate assertions.
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [11:0] alu_f;
    logic [31:0] alu_y;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
`ifdef ALU_SEQ_ZFLAG_EN
    logic        res_zero;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign alu_y = alu_f[1] ? alu_a - alu_b : alu_a + alu_b;

    alu_op_sequencer #(.DATA_W(32), .OP_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
`ifdef ALU_SEQ_ZFLAG_EN
        ,
        .res_zero  (res_zero)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("accept_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input bit gap);
        send_byte(op);
        if (gap) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) begin
            send_byte(a[8*i +: 8]);
            if (gap) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(b[8*i +: 8]);
            if (gap && i < 3) begin @(posedge clk); #1; end
        end
    endtask

    task automatic run_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input bit gap,
                             input logic [11:0] ef, input logic [31:0] ey, input logic ee);
        send_frame(op, a, b, gap);
        chk("exec_in_ready", {63'd0, in_ready}, 64'd0);
        chk("exec_res_valid", {63'd0, res_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("res_valid", {63'd0, res_valid}, 64'd1);
        chk("res_data", {32'd0, res_data}, {32'd0, ey});
        chk("res_err", {63'd0, res_err}, {63'd0, ee});
        chk("alu_f", {52'd0, alu_f}, {52'd0, ef});
        chk("alu_a", {32'd0, alu_a}, {32'd0, a});
        chk("alu_b", {32'd0, alu_b}, {32'd0, b});
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("post_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_res_valid", {63'd0, res_valid}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'd0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_alu_f", {52'd0, alu_f}, 64'd0);
        chk("rst_res_data", {32'd0, res_data}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_frame(8'd0, 32'h5, 32'h3, 1'b0, 12'h001, 32'h8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_res_data", {32'd0, res_data}, 64'h8);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_res_valid", {63'd0, res_valid}, 64'd1);
        end
        release_result();

        run_frame(8'd12, 32'hDEADBEEF, 32'h12345678, 1'b0, 12'h000, 32'h0, 1'b1);
        release_result();

        run_frame(8'd0, 32'h12345678, 32'h1, 1'b1, 12'h001, 32'h12345679, 1'b0);
        release_result();

        send_byte(8'd0);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_a", {32'd0, alu_a}, 64'd0);
        chk("mid_rst_alu_b", {32'd0, alu_b}, 64'd0);
        chk("mid_rst_alu_f", {52'd0, alu_f}, 64'd0);
        chk("mid_rst_res_data", {32'd0, res_data}, 64'd0);
        chk("mid_rst_res_err", {63'd0, res_err}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(8'd11, 32'hFFFFFFFF, 32'h1, 1'b0, 12'h800, 32'h0, 1'b0);
        release_result();

        run_frame(8'd1, 32'h0000ABCD, 32'h0000ABCD, 1'b0, 12'h002, 32'h0, 1'b0);
`ifdef ALU_SEQ_ZFLAG_EN
        chk("res_zero_set", {63'd0, res_zero}, 64'd1);
`endif
        release_result();

        run_frame(8'd1, 32'h10, 32'h3, 1'b0, 12'h002, 32'hD, 1'b0);
`ifdef ALU_SEQ_ZFLAG_EN
        chk("res_zero_clr", {63'd0, res_zero}, 64'd0);
`endif
        release_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
